zombie_wave_ctrl: RTL



---
 rtl/zombie_wave_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/zombie_wave_ctrl.sv
// zombie_wave_ctrl: game-logic stage feeding the lawn renderer.
// It runs the game-state FSM, spawns zombies into five lanes, moves them left
// on a divided tick, and applies kills. It reports per-lane position and
// active flags, the total kill count, and the win/lose status.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   freeze               (ZOMBIE_FREEZE_EN only) holds the tick counter
//   start                1-cycle pulse: I->L1, DoneL/DoneW->I
//   kill_valid/kill_lane kill request for lane 0-4 (5-7 are ignored)
//   zombie_x[49:0]       lane n X at [10n+9:10n]
//   zombie_active[4:0]   lane n has a live zombie
//   state[7:0]           one-hot I,L1,NL2,L2,NL3,L3,DoneL,DoneW
//   zombies_killed[15:0] kills since leaving I, saturating
//   lose / win           state==DoneL / state==DoneW
//
// Optional feature macro: ZOMBIE_FREEZE_EN (adds the freeze input).

module zombie_wave_lane #(
  parameter logic [9:0] START_X = 10'd639,
  parameter logic [9:0] END_X   = 10'd0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_clr,
  input  logic       i_tick,
  input  logic [1:0] i_speed,
  input  logic       i_kill,
  input  logic       i_spawn,
  output logic [9:0] o_x,
  output logic       o_active,
  output logic       o_reach
);
  logic [9:0] r_x;
  logic       r_active;
  logic       w_at_end;

  // 11-bit compare so END_X+speed cannot wrap
  assign w_at_end = {1'b0, r_x} <= ({1'b0, END_X} + {9'd0, i_speed});
  // a kill on this lane in the same cycle pre-empts the loss
  assign o_reach  = r_active & i_tick & ~i_kill & w_at_end;

  // priority: clear/kill > reach-end > move > spawn (spawn needs an empty lane)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x      <= START_X;
      r_active <= 1'b0;
    end else if (i_clr || i_kill) begin
      r_x      <= START_X;
      r_active <= 1'b0;
    end else if (o_reach) begin
      r_x      <= END_X;
    end else if (r_active && i_tick) begin
      r_x      <= r_x - {8'd0, i_speed};
    end else if (!r_active && i_spawn) begin
      r_x      <= START_X;
      r_active <= 1'b1;
    end
  end

  assign o_x      = r_x;
  assign o_active = r_active;
endmodule

module zombie_wave_ctrl #(
  parameter int unsigned TICK_DIV        = 500000,
  parameter logic [9:0]  START_X         = 10'd639,
  parameter logic [9:0]  END_X           = 10'd0,
  parameter logic [7:0]  SPAWN_GAP       = 8'd64,
  parameter logic [7:0]  KILLS_PER_LEVEL = 8'd10,
  parameter logic [7:0]  PAUSE_TICKS     = 8'd128
) (
  input  logic        clk,
  input  logic        reset_n,
`ifdef ZOMBIE_FREEZE_EN
  input  logic        freeze,
`endif
  input  logic        start,
  input  logic        kill_valid,
  input  logic [2:0]  kill_lane,
  output logic [49:0] zombie_x,
  output logic [4:0]  zombie_active,
  output logic [7:0]  state,
  output logic [15:0] zombies_killed,
  output logic        lose,
  output logic        win
);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [7:0] S_I = 8'h01, S_L1 = 8'h02, S_NL2 = 8'h04, S_L2 = 8'h08,
                         S_NL3 = 8'h10, S_L3 = 8'h20, S_DL = 8'h40, S_DW = 8'h80;

  logic [7:0]    r_state, w_state_nxt;
  logic          r_lose, r_win, w_lose_nxt, w_win_nxt;
  logic [TW-1:0] r_tick_cnt;
  logic [7:0]    r_lfsr, w_lfsr_nxt;
  logic [7:0]    r_spawn_cnt, r_pause_cnt, r_lvl_kills, w_lvl_inc;
  logic [15:0]   r_kills;
  logic          r_reached;
  logic          w_play, w_pause, w_cnt_en, w_tick, w_mv_tick, w_spawn_try;
  logic          w_pause_done, w_kill_ok, w_adv, w_clr, w_frz;
  logic [1:0]    w_speed;
  logic [2:0]    w_spawn_lane;
  logic [4:0]    w_active, w_reach, w_kill_hit, w_spawn_hit;

`ifdef ZOMBIE_FREEZE_EN
  assign w_frz = freeze;
`else
  assign w_frz = 1'b0;
`endif

  assign w_play   = |(r_state & (S_L1 | S_L2 | S_L3));
  assign w_pause  = |(r_state & (S_NL2 | S_NL3));
  assign w_cnt_en = (w_play | w_pause) & ~w_frz;
  assign w_tick   = w_cnt_en && (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_mv_tick = w_tick & w_play;
  assign w_speed  = (r_state == S_L1) ? 2'd1 : (r_state == S_L2) ? 2'd2 :
                    (r_state == S_L3) ? 2'd3 : 2'd0;

  // Fibonacci LFSR, taps 8,6,5,4; the lane uses the advanced value
  assign w_lfsr_nxt   = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_spawn_lane = 3'(w_lfsr_nxt % 8'd5);
  assign w_spawn_try  = w_mv_tick && (r_spawn_cnt == SPAWN_GAP - 8'd1);
  assign w_pause_done = w_pause && w_tick && (r_pause_cnt == PAUSE_TICKS - 8'd1);

  always_comb begin
    w_kill_hit  = '0;
    w_spawn_hit = '0;
    for (int i = 0; i < 5; i++) begin
      w_kill_hit[i]  = kill_valid & w_play & w_active[i] & (kill_lane == 3'(i));
      w_spawn_hit[i] = w_spawn_try & (w_spawn_lane == 3'(i));
    end
  end
  assign w_kill_ok = |w_kill_hit;
  assign w_lvl_inc = r_lvl_kills + 8'd1;
  assign w_adv     = w_kill_ok && (w_lvl_inc >= KILLS_PER_LEVEL);
  // lanes are only populated in play states; anything else empties them
  assign w_clr     = ~|(w_state_nxt & (S_L1 | S_L2 | S_L3));

  for (genvar g = 0; g < 5; g++) begin : g_lane
    zombie_wave_lane #(.START_X(START_X), .END_X(END_X)) u_lane (
      .clk(clk), .reset_n(reset_n), .i_clr(w_clr), .i_tick(w_mv_tick),
      .i_speed(w_speed), .i_kill(w_kill_hit[g]), .i_spawn(w_spawn_hit[g]),
      .o_x(zombie_x[10*g +: 10]), .o_active(w_active[g]), .o_reach(w_reach[g]));
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_I;
      r_lose  <= 1'b0;
      r_win   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lose  <= w_lose_nxt;
      r_win   <= w_win_nxt;
    end
  end

  // next state; a reach holds the level one cycle so the loss beats any advance
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_I:               if (start) w_state_nxt = S_L1;
      S_L1, S_L2, S_L3: begin
        if (r_reached)     w_state_nxt = S_DL;
        else if (|w_reach) w_state_nxt = r_state;
        else if (w_adv)    w_state_nxt = (r_state == S_L1) ? S_NL2 :
                                         (r_state == S_L2) ? S_NL3 : S_DW;
      end
      S_NL2:             if (w_pause_done) w_state_nxt = S_L2;
      S_NL3:             if (w_pause_done) w_state_nxt = S_L3;
      S_DL, S_DW:        if (start) w_state_nxt = S_I;
      default:           w_state_nxt = S_I;
    endcase
  end

  // outputs
  always_comb begin
    w_lose_nxt = (w_state_nxt == S_DL);
    w_win_nxt  = (w_state_nxt == S_DW);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt  <= '0;
      r_lfsr      <= 8'hA5;
      r_spawn_cnt <= '0;
      r_pause_cnt <= '0;
      r_lvl_kills <= '0;
      r_kills     <= '0;
      r_reached   <= 1'b0;
    end else begin
      if (!(w_play | w_pause))  r_tick_cnt <= '0;
      else if (w_tick)          r_tick_cnt <= '0;
      else if (w_cnt_en)        r_tick_cnt <= r_tick_cnt + TW'(1);

      if (w_tick) r_lfsr <= w_lfsr_nxt;

      if (!w_play)          r_spawn_cnt <= '0;
      else if (w_spawn_try) r_spawn_cnt <= '0;
      else if (w_mv_tick)   r_spawn_cnt <= r_spawn_cnt + 8'd1;

      if (!w_pause)    r_pause_cnt <= '0;
      else if (w_tick) r_pause_cnt <= r_pause_cnt + 8'd1;

      if (w_clr)          r_lvl_kills <= '0;
      else if (w_kill_ok) r_lvl_kills <= w_lvl_inc;

      if (((r_state == S_DL) || (r_state == S_DW)) && start) r_kills <= '0;
      else if (w_kill_ok && (r_kills != 16'hFFFF))           r_kills <= r_kills + 16'd1;

      r_reached <= |w_reach;
    end
  end

  assign zombie_active  = w_active;
  assign state          = r_state;
  assign zombies_killed = r_kills;
  assign lose           = r_lose;
  assign win            = r_win;
endmodule
